// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: word geometry, opcode encodings and the
// program-loader state set, used by the CPU, loader and assembler tasks.
package mcpu_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int OPCODE_SIZE  = 4;
    localparam int OPERAND_SIZE = WORD_SIZE - OPCODE_SIZE;
    localparam int RAM_SIZE     = 256;
    localparam int ADDR_WIDTH   = $clog2(RAM_SIZE);

    localparam logic [OPCODE_SIZE-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_SIZE-1:0] OP_LDI  = 4'h1;
    localparam logic [OPCODE_SIZE-1:0] OP_LD   = 4'h2;
    localparam logic [OPCODE_SIZE-1:0] OP_ST   = 4'h3;
    localparam logic [OPCODE_SIZE-1:0] OP_ADD  = 4'h4;
    localparam logic [OPCODE_SIZE-1:0] OP_SUB  = 4'h5;
    localparam logic [OPCODE_SIZE-1:0] OP_JMP  = 4'h6;
    localparam logic [OPCODE_SIZE-1:0] OP_BNZ  = 4'h7;
    localparam logic [OPCODE_SIZE-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        FLUSH,
        RUN,
        ERR
    } loader_state_t;

    function automatic logic [WORD_SIZE-1:0] make_instr(
        input logic [OPCODE_SIZE-1:0]  op,
        input logic [OPERAND_SIZE-1:0] operand
    );
        return {op, operand};
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: holds the MCPU in reset, optionally zero-fills
// RAM, streams an instruction image into RAM from address 0, then releases the CPU.
module prog_loader
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE  = mcpu_pkg::WORD_SIZE,
    parameter int RAM_SIZE   = mcpu_pkg::RAM_SIZE,
    parameter int ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH,
    parameter int CLEAR_MEM  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [WORD_SIZE-1:0]  in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_SIZE-1:0]  ram_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT  = (ADDR_WIDTH+1)'(RAM_SIZE);
    localparam loader_state_t         FIRST_PHASE = (CLEAR_MEM != 0) ? CLEAR : LOAD;

    loader_state_t          state, nxt_state;
    logic [ADDR_WIDTH-1:0]  cnt, nxt_cnt;
    logic [ADDR_WIDTH:0]    nxt_words_loaded;
    logic                   nxt_ram_we;
    logic [ADDR_WIDTH-1:0]  nxt_ram_addr;
    logic [WORD_SIZE-1:0]   nxt_ram_wdata;
    logic                   nxt_cpu_reset;
    logic                   nxt_done;
    logic                   nxt_error;
    logic                   accept;
    logic                   full;
    logic                   restart;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign full     = (words_loaded == FULL_COUNT);
    assign restart  = start && (state == IDLE || state == RUN || state == ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:     if (start) nxt_state = FIRST_PHASE;
            CLEAR:    if (cnt == LAST_ADDR) nxt_state = LOAD;
            LOAD: begin
                if (accept) begin
                    if (full) begin
                        nxt_state = ERR;
                    end else if (in_last) begin
                        nxt_state = FLUSH;
                    end
                end
            end
            FLUSH:    nxt_state = RUN;
            RUN, ERR: if (start) nxt_state = FIRST_PHASE;
            default:  nxt_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_cnt          = cnt;
        nxt_words_loaded = words_loaded;
        nxt_ram_we       = 1'b0;
        nxt_ram_addr     = ram_addr;
        nxt_ram_wdata    = ram_wdata;
        nxt_cpu_reset    = cpu_reset;
        nxt_done         = done;
        nxt_error        = error;

        if (restart) begin
            nxt_cnt          = '0;
            nxt_words_loaded = '0;
            nxt_cpu_reset    = 1'b1;
            nxt_done         = 1'b0;
            nxt_error        = 1'b0;
        end

        case (state)
            CLEAR: begin
                nxt_ram_we    = 1'b1;
                nxt_ram_addr  = cnt;
                nxt_ram_wdata = '0;
                nxt_cnt       = (cnt == LAST_ADDR) ? '0 : cnt + 1'b1;
            end
            LOAD: begin
                // Overflow is caught before the write, so no address past the top is ever driven.
                if (accept && full) begin
                    nxt_error = 1'b1;
                end else if (accept) begin
                    nxt_ram_we       = 1'b1;
                    nxt_ram_addr     = words_loaded[ADDR_WIDTH-1:0];
                    nxt_ram_wdata    = in_data;
                    nxt_words_loaded = words_loaded + 1'b1;
                end
            end
            FLUSH: begin
                nxt_done      = 1'b1;
                nxt_cpu_reset = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            words_loaded <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            cnt          <= nxt_cnt;
            words_loaded <= nxt_words_loaded;
            ram_we       <= nxt_ram_we;
            ram_addr     <= nxt_ram_addr;
            ram_wdata    <= nxt_ram_wdata;
            cpu_reset    <= nxt_cpu_reset;
            done         <= nxt_done;
            error        <= nxt_error;
        end
    end

endmodule
